oam_dma: RTL

OAM DMA engine between the CPU bus master and the MMU. A CPU write to register 0xFF46 latches a source page and copies 160 bytes from {page, 0x00..0x9F} to 0xFE00..0xFE9F. The copy runs over the shared memory port, one byte per slot. While the copy is active, CPU traffic is restricted to HRAM (0xFF80–0xFFFE) and to 0xFF46 itself. CPU-side ports face the CPU bus; memory-side ports drive the MMU.

---
 rtl/oam_dma.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/oam_dma.sv
// OAM DMA engine: copies 160 bytes from a CPU-selected page into 0xFE00..0xFE9F
// and restricts CPU traffic to HRAM while active. Optional macro: OAM_DMA_ECHO_MAP_EN.
module oam_dma #(
   parameter int CYCLES_PER_BYTE = 4,
   parameter int START_DELAY     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   output logic [7:0]  cpu_rdata,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [7:0]  mem_rdata,
   output logic        dma_active,
   output logic [1:0]  dbg_state
);

   localparam int SW = $clog2(CYCLES_PER_BYTE);
   localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(CYCLES_PER_BYTE - 1);
   localparam logic [DW-1:0] DLY_LAST  = DW'(START_DELAY - 1);
   localparam logic [7:0]    IDX_LAST  = 8'd159;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      XFER  = 2'd2
   } state_t;

   state_t         state, state_nx;
   logic [7:0]     page, idx, data_buf;
   logic [SW-1:0]  slot;
   logic [DW-1:0]  dly;
   logic           restart;

   logic           reg_hit, reg_wr, hram_hit, dma_slot_busy;
   logic           dma_rd_slot, dma_wr_slot, fwd_ok, fwd_rd, fwd_wr;
   logic [7:0]     src_page;

   // Valid/strobe semantics: cpu_rd/cpu_wr and mem_rd/mem_wr are single-cycle
   // strobes with no backpressure; the MMU answers mem_rdata in the same cycle.
   always_comb begin
      reg_hit       = (cpu_addr == 16'hFF46);
      reg_wr        = cpu_wr && reg_hit;
      hram_hit      = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
      dma_active    = (state == XFER) || ((state == START) && restart);
      dma_slot_busy = (state == XFER) && ((slot == '0) || (slot == SLOT_LAST));
      dma_rd_slot   = (state == XFER) && (slot == '0);
      // A restart landing on the write slot abandons that byte.
      dma_wr_slot   = (state == XFER) && (slot == SLOT_LAST) && !reg_wr;
      fwd_ok        = !reg_hit && (!dma_active || (hram_hit && !dma_slot_busy));
      fwd_rd        = reset && fwd_ok && cpu_rd;
      fwd_wr        = reset && fwd_ok && cpu_wr;
`ifdef OAM_DMA_ECHO_MAP_EN
      src_page      = (page >= 8'hE0) ? (page - 8'h20) : page;
`else
      src_page      = page;
`endif
   end

   always_comb begin
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = 16'h0000;
      mem_wdata = 8'h00;
      if (dma_rd_slot) begin
         mem_rd   = 1'b1;
         mem_addr = {src_page, idx};
      end else if (dma_wr_slot) begin
         mem_wr    = 1'b1;
         mem_addr  = 16'hFE00 + {8'h00, idx};
         mem_wdata = data_buf;
      end else if (fwd_rd || fwd_wr) begin
         mem_rd    = fwd_rd;
         mem_wr    = fwd_wr;
         mem_addr  = cpu_addr;
         mem_wdata = fwd_wr ? cpu_wdata : 8'h00;
      end
   end

   always_comb begin
      cpu_rdata = 8'hFF;
      if (cpu_rd && reg_hit) begin
         cpu_rdata = page;
      end else if (fwd_rd) begin
         cpu_rdata = mem_rdata;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  state_nx = IDLE;
         START: if (dly == DLY_LAST) state_nx = XFER;
         XFER:  if ((slot == SLOT_LAST) && (idx == IDX_LAST)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (reg_wr) begin
         state_nx = START;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         page     <= 8'h00;
         idx      <= 8'h00;
         slot     <= '0;
         dly      <= '0;
         data_buf <= 8'h00;
         restart  <= 1'b0;
      end else if (reg_wr) begin
         page    <= cpu_wdata;
         idx     <= 8'h00;
         slot    <= '0;
         dly     <= '0;
         // Remember whether the bus was already restricted so START keeps it so.
         restart <= dma_active;
      end else begin
         case (state)
            IDLE: restart <= 1'b0;
            START: begin
               if (dly != DLY_LAST) begin
                  dly <= dly + DW'(1);
               end
            end
            XFER: begin
               if (slot == '0) begin
                  data_buf <= mem_rdata;
               end
               if (slot == SLOT_LAST) begin
                  slot <= '0;
                  if (idx != IDX_LAST) begin
                     idx <= idx + 8'd1;
                  end
               end else begin
                  slot <= slot + SW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign dbg_state = state;

endmodule
